// File: rtl/jesd204_rx_align_err_ctrl.sv
// JESD204 RX frame-alignment error controller: round-robin lane scan, resync req/ack, hold-off.
// Optional request timeout enabled by defining JESD204_RX_ALIGN_CTRL_TIMEOUT_EN.
module jesd204_rx_align_err_ctrl #(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned TIMEOUT_LOG2 = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_enable,
    input  logic [NUM_LANES-1:0]   cfg_lanes_disable,
    input  logic [7:0]             cfg_err_threshold,
    input  logic [15:0]            cfg_holdoff_beats,
    input  logic                   link_ready,
    input  logic [NUM_LANES*8-1:0] lane_align_err_cnt,
    input  logic                   resync_ack,
    output logic                   resync_req,
    output logic [NUM_LANES-1:0]   err_lane_mask,
    output logic [7:0]             resync_count,
    output logic [1:0]             state,
    output logic                   req_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_REQUEST = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    if (NUM_LANES < 1 || NUM_LANES > 32 || TIMEOUT_LOG2 < 1) begin : g_param_check
        $error("jesd204_rx_align_err_ctrl: NUM_LANES must be 1..32 and TIMEOUT_LOG2 >= 1");
    end

    state_t           cur_state;
    state_t           nxt_state;
    logic [IDX_W-1:0] scan_idx;
    logic [15:0]      hold_cnt;
    logic [7:0]       lane_cnt;
    logic             lane_hit;
    logic             timeout_hit;
    logic             req_d;

    assign lane_cnt = lane_align_err_cnt[{scan_idx, 3'b000} +: 8];
    assign lane_hit = !cfg_lanes_disable[scan_idx] && (cfg_err_threshold != 8'd0) &&
                      (lane_cnt >= cfg_err_threshold);

`ifdef JESD204_RX_ALIGN_CTRL_TIMEOUT_EN
    logic [TIMEOUT_LOG2-1:0] to_cnt;
    logic                    to_flag;

    // Counter is zero on the first REQUEST cycle, so all-ones marks the last allowed cycle.
    assign timeout_hit = (cur_state == ST_REQUEST) && !resync_ack && (&to_cnt);
    assign req_timeout = to_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (cur_state == ST_REQUEST)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (timeout_hit)
                to_flag <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign req_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            cur_state <= ST_IDLE;
        else
            cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (cfg_enable && link_ready)
                    nxt_state = ST_MONITOR;
            end
            ST_MONITOR: begin
                if (|err_lane_mask)
                    nxt_state = ST_REQUEST;
                else if (!cfg_enable || !link_ready)
                    nxt_state = ST_IDLE;
            end
            ST_REQUEST: begin
                if (resync_ack || timeout_hit)
                    nxt_state = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (hold_cnt == 16'd0)
                    nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d = (nxt_state == ST_REQUEST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resync_req    <= 1'b0;
            err_lane_mask <= '0;
            resync_count  <= '0;
            scan_idx      <= '0;
            hold_cnt      <= '0;
        end else begin
            resync_req <= req_d;
            case (cur_state)
                ST_IDLE: begin
                    if (nxt_state == ST_MONITOR) begin
                        err_lane_mask <= '0;
                        scan_idx      <= '0;
                    end
                end
                ST_MONITOR: begin
                    scan_idx <= (scan_idx == IDX_W'(NUM_LANES - 1)) ? '0 : scan_idx + 1'b1;
                    if (lane_hit)
                        err_lane_mask[scan_idx] <= 1'b1;
                end
                ST_REQUEST: begin
                    if (resync_ack) begin
                        if (resync_count != 8'hFF)
                            resync_count <= resync_count + 8'd1;
                        hold_cnt <= cfg_holdoff_beats;
                    end else if (timeout_hit) begin
                        hold_cnt <= cfg_holdoff_beats;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt != 16'd0)
                        hold_cnt <= hold_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign state = cur_state;

endmodule
